// File: rtl/maze_pose_navigator.sv
// Per-frame maze pose update: right-hand wall following with centring
// correction, pose clamping, and goal/stuck detection.
module maze_pose_navigator #(
  parameter int CENTER_H     = 15,
  parameter int CENTER_V     = 8,
  parameter int STEP         = 4,
  parameter int MAX_CORR     = 3,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int GOAL_TOL     = 4,
  parameter int STUCK_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        video_frame_valid,
  input  logic        mazeParametersDefined,
  input  logic [9:0]  start_h,
  input  logic [9:0]  start_v,
  input  logic [9:0]  goal_h,
  input  logic [9:0]  goal_v,
  input  logic [3:0]  states,
  input  logic [9:0]  bottom_center,
  input  logic [9:0]  left_center,
  input  logic [9:0]  upper_center,
  input  logic [9:0]  right_center,
  output logic [25:0] curPose,
  output logic        pose_valid,
  output logic        goal_reached,
  output logic        stuck,
  output logic [15:0] move_cnt
);

  localparam int SW = $clog2(STUCK_FRAMES + 1);

  localparam logic signed [11:0] L_STEP = 12'(STEP);
  localparam logic signed [11:0] L_CORR = 12'(MAX_CORR);
  localparam logic signed [11:0] L_CH   = 12'(CENTER_H);
  localparam logic signed [11:0] L_CV   = 12'(CENTER_V);
  localparam logic signed [11:0] L_HMIN = 12'(CENTER_H);
  localparam logic signed [11:0] L_HMAX = 12'(H_ACTIVE - 1 - CENTER_H);
  localparam logic signed [11:0] L_VMIN = 12'(CENTER_V);
  localparam logic signed [11:0] L_VMAX = 12'(V_ACTIVE - 1 - CENTER_V);
  localparam logic signed [11:0] L_TOL  = 12'(GOAL_TOL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DECIDE,
    S_MOVE,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic          r_vfv_d;
  logic [9:0]    r_h, r_v;
  logic [1:0]    r_hd;
  logic          r_pgoal;
  logic          r_goal;
  logic          r_pv;
  logic          r_stuck;
  logic [SW-1:0] r_scnt;
  logic [3:0]    r_st;
  logic [9:0]    r_bc, r_lc, r_uc, r_rc;
  logic [1:0]    r_dir;
  logic [15:0]   r_cnt;

  logic        w_cap;
  logic        w_drop;
  logic [1:0]  w_c0, w_c1, w_c2, w_c3;
  logic        w_any;
  logic [1:0]  w_dir;

  logic              w_vert;
  logic [9:0]        w_cen;
  logic signed [11:0] w_diff, w_corr;
  logic signed [11:0] w_hs, w_vs;
  logic [9:0]        w_hc, w_vc;
  logic signed [11:0] w_dh, w_dv;
  logic              w_goal;

  assign w_cap  = r_vfv_d & ~video_frame_valid;
  assign w_drop = (r_state != S_IDLE) & ~mazeParametersDefined;

  assign w_c0 = r_hd + 2'd1;
  assign w_c1 = r_hd;
  assign w_c2 = r_hd + 2'd3;
  assign w_c3 = r_hd + 2'd2;
  assign w_any = |r_st;

  always_comb begin
    w_dir = w_c3;
    if (r_st[2'd3 - w_c0])      w_dir = w_c0;
    else if (r_st[2'd3 - w_c1]) w_dir = w_c1;
    else if (r_st[2'd3 - w_c2]) w_dir = w_c2;
  end

  // Correction is lateral to travel: vertical moves nudge h, horizontal nudge v.
  always_comb begin
    w_vert = ~r_dir[0];
    w_cen  = r_bc;
    unique case (r_dir)
      2'd0: w_cen = r_bc;
      2'd1: w_cen = r_lc;
      2'd2: w_cen = r_uc;
      2'd3: w_cen = r_rc;
    endcase
    w_diff = $signed({2'b00, w_cen}) - (w_vert ? L_CH : L_CV);
    w_corr = w_diff;
    if (w_diff > L_CORR)  w_corr = L_CORR;
    if (w_diff < -L_CORR) w_corr = -L_CORR;
    w_hs = $signed({2'b00, r_h});
    w_vs = $signed({2'b00, r_v});
    unique case (r_dir)
      2'd0: begin w_vs = w_vs + L_STEP; w_hs = w_hs + w_corr; end
      2'd1: begin w_hs = w_hs - L_STEP; w_vs = w_vs + w_corr; end
      2'd2: begin w_vs = w_vs - L_STEP; w_hs = w_hs + w_corr; end
      2'd3: begin w_hs = w_hs + L_STEP; w_vs = w_vs + w_corr; end
    endcase
    if (w_hs < L_HMIN)      w_hc = L_HMIN[9:0];
    else if (w_hs > L_HMAX) w_hc = L_HMAX[9:0];
    else                    w_hc = w_hs[9:0];
    if (w_vs < L_VMIN)      w_vc = L_VMIN[9:0];
    else if (w_vs > L_VMAX) w_vc = L_VMAX[9:0];
    else                    w_vc = w_vs[9:0];
    w_dh = $signed({2'b00, w_hc}) - $signed({2'b00, goal_h});
    w_dv = $signed({2'b00, w_vc}) - $signed({2'b00, goal_v});
    if (w_dh < 0) w_dh = -w_dh;
    if (w_dv < 0) w_dv = -w_dv;
    w_goal = (w_dh <= L_TOL) && (w_dv <= L_TOL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_drop) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (mazeParametersDefined) w_next = S_WAIT;
        S_WAIT:   if (w_cap) w_next = S_DECIDE;
        S_DECIDE: w_next = w_any ? S_MOVE : S_WAIT;
        S_MOVE:   w_next = w_goal ? S_DONE : S_WAIT;
        S_DONE:   w_next = S_DONE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vfv_d <= 1'b0;
      r_h     <= '0;
      r_v     <= '0;
      r_hd    <= '0;
      r_pgoal <= 1'b0;
      r_goal  <= 1'b0;
      r_pv    <= 1'b0;
      r_stuck <= 1'b0;
      r_scnt  <= '0;
      r_st    <= '0;
      r_bc    <= '0;
      r_lc    <= '0;
      r_uc    <= '0;
      r_rc    <= '0;
      r_dir   <= '0;
      r_cnt   <= '0;
    end else begin
      r_vfv_d <= video_frame_valid;
      r_pv    <= 1'b0;
      if (w_drop) begin
        r_goal  <= 1'b0;
        r_stuck <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: if (mazeParametersDefined) begin
            r_h     <= start_h;
            r_v     <= start_v;
            r_hd    <= 2'd0;
            r_pgoal <= 1'b0;
            r_goal  <= 1'b0;
            r_cnt   <= '0;
            r_scnt  <= '0;
            r_stuck <= 1'b0;
          end
          S_WAIT: if (w_cap) begin
            r_st <= states;
            r_bc <= bottom_center;
            r_lc <= left_center;
            r_uc <= upper_center;
            r_rc <= right_center;
          end
          S_DECIDE: begin
            if (w_any) begin
              r_dir   <= w_dir;
              r_scnt  <= '0;
              r_stuck <= 1'b0;
            end else begin
              if (int'(r_scnt) < STUCK_FRAMES) r_scnt <= r_scnt + 1'b1;
              if (int'(r_scnt) >= STUCK_FRAMES - 1) r_stuck <= 1'b1;
            end
          end
          S_MOVE: begin
            r_h  <= w_hc;
            r_v  <= w_vc;
            r_hd <= r_dir;
            r_pv <= 1'b1;
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            if (w_goal) begin
              r_goal  <= 1'b1;
              r_pgoal <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign curPose      = {3'b000, r_pgoal, r_hd, r_h, r_v};
  assign pose_valid   = r_pv;
  assign goal_reached = r_goal;
  assign stuck        = r_stuck;
  assign move_cnt     = r_cnt;

endmodule
